// File: rtl/adc_lvds_capture.sv
// Capture engine for 8 serial ADC lanes: CNV pulse, conversion wait, 16-bit MSB-first shift, 128-bit word out.
// Latency: one packed word per CNV_LOW + T_CONV + 2*CLK_DIV*N_BITS + 1 clk; o_finished the cycle after the last word.
// Backpressure: none; o_rdy is a write strobe and the downstream FIFO is sized so it never fills.
//
// Ports: clk/rst (async active-high); i_start, i_calib_done, i_samples_count, i_debug_en control a run;
// i_ADC_SDO[k] is lane k serial data; o_ADC_SCK/o_ADC_CNV_n drive the 4 ADC pairs (all bits identical);
// o_data/o_rdy carry one packed word per conversion (lane k at [16k+:16]); o_finished, o_busy report run status.
module adc_lvds_capture #(
    parameter int CLK_DIV = 2,
    parameter int CNV_LOW = 2,
    parameter int T_CONV  = 20,
    parameter int N_BITS  = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_start,
    input  logic         i_calib_done,
    input  logic [31:0]  i_samples_count,
    input  logic         i_debug_en,
    input  logic [7:0]   i_ADC_SDO,
    output logic [3:0]   o_ADC_SCK,
    output logic [3:0]   o_ADC_CNV_n,
    output logic [127:0] o_data,
    output logic         o_rdy,
    output logic         o_finished,
    output logic         o_busy
);

    localparam int CW = 16;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CNV,
        S_WAIT,
        S_SHIFT,
        S_EMIT,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [4:0]          bit_q, bit_d;
    logic [31:0]         remaining_q, remaining_d;
    logic [12:0]         sidx_q, sidx_d;
    logic [7:0][15:0]    shift_q, shift_d;
    logic                sck_q, sck_d;
    logic                cnv_n_q, cnv_n_d;
    logic [127:0]        data_q, data_d;
    logic                rdy_q, rdy_d;
    logic                fin_q, fin_d;
    logic                busy_q, busy_d;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_d       = bit_q;
        remaining_d = remaining_q;
        sidx_d      = sidx_q;
        shift_d     = shift_q;
        sck_d       = sck_q;
        data_d      = data_q;

        case (state_q)
            S_IDLE: begin
                if (i_start && i_calib_done) begin
                    remaining_d = i_samples_count;
                    sidx_d      = '0;
                    cnt_d       = '0;
                    state_d     = (i_samples_count == 32'd0) ? S_DONE : S_CNV;
                end
            end
            S_CNV: begin
                if (cnt_q == CW'(CNV_LOW - 1)) begin
                    cnt_d   = '0;
                    state_d = S_WAIT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_WAIT: begin
                if (cnt_q == CW'(T_CONV - 1)) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = S_SHIFT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_SHIFT: begin
                // cnt_q times each SCK half-period; lanes are sampled on the
                // edge that ends the high half, where SDO has had a full half to settle.
                if (cnt_q == CW'(CLK_DIV - 1)) begin
                    cnt_d = '0;
                    if (!sck_q) begin
                        sck_d = 1'b1;
                    end else begin
                        sck_d = 1'b0;
                        for (int k = 0; k < 8; k++) begin
                            shift_d[k] = {shift_q[k][14:0], i_ADC_SDO[k]};
                        end
                        if (bit_q == 5'(N_BITS - 1)) begin
                            state_d = S_EMIT;
                        end else begin
                            bit_d = bit_q + 1'b1;
                        end
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_EMIT: begin
                sidx_d      = sidx_q + 1'b1;
                remaining_d = remaining_q - 1'b1;
                cnt_d       = '0;
                state_d     = (remaining_q == 32'd1) ? S_DONE : S_CNV;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Outputs are registered from the next state so they line up with the
        // state they describe (e.g. o_rdy is high exactly during EMIT).
        cnv_n_d = (state_d != S_CNV);
        busy_d  = (state_d != S_IDLE);
        fin_d   = (state_d == S_DONE);
        rdy_d   = (state_d == S_EMIT);
        if (state_d == S_EMIT) begin
            if (i_debug_en) begin
                for (int k = 0; k < 8; k++) begin
                    data_d[16*k +: 16] = {sidx_q, 3'(k)};
                end
            end else begin
                data_d = shift_d;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            bit_q       <= '0;
            remaining_q <= '0;
            sidx_q      <= '0;
            shift_q     <= '0;
            sck_q       <= 1'b0;
            cnv_n_q     <= 1'b1;
            data_q      <= '0;
            rdy_q       <= 1'b0;
            fin_q       <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_q       <= bit_d;
            remaining_q <= remaining_d;
            sidx_q      <= sidx_d;
            shift_q     <= shift_d;
            sck_q       <= sck_d;
            cnv_n_q     <= cnv_n_d;
            data_q      <= data_d;
            rdy_q       <= rdy_d;
            fin_q       <= fin_d;
            busy_q      <= busy_d;
        end
    end

    assign o_ADC_SCK   = {4{sck_q}};
    assign o_ADC_CNV_n = {4{cnv_n_q}};
    assign o_data      = data_q;
    assign o_rdy       = rdy_q;
    assign o_finished  = fin_q;
    assign o_busy      = busy_q;

endmodule

// File: tb/tb_adc_lvds_capture.sv
// Bench for adc_lvds_capture: per-cycle comparison against a run-position model.
// Latency: model predicts every output from the cycle count since start acceptance.
// Backpressure: none; SDO is driven by an ADC model that follows the DUT's SCK.
module tb_adc_lvds_capture;

    localparam int  CLK_DIV = 2;
    localparam int  CNV_LOW = 2;
    localparam int  T_CONV  = 20;
    localparam int  NB      = 16;
    localparam int  SHIFT0  = CNV_LOW + T_CONV;
    localparam longint PER  = CNV_LOW + T_CONV + 2 * CLK_DIV * NB + 1;

    logic         clk = 1'b0;
    logic         rst;
    logic         i_start;
    logic         i_calib_done;
    logic [31:0]  i_samples_count;
    logic         i_debug_en;
    logic [7:0]   i_ADC_SDO;
    logic [3:0]   o_ADC_SCK;
    logic [3:0]   o_ADC_CNV_n;
    logic [127:0] o_data;
    logic         o_rdy;
    logic         o_finished;
    logic         o_busy;

    adc_lvds_capture dut (
        .clk(clk), .rst(rst), .i_start(i_start), .i_calib_done(i_calib_done),
        .i_samples_count(i_samples_count), .i_debug_en(i_debug_en), .i_ADC_SDO(i_ADC_SDO),
        .o_ADC_SCK(o_ADC_SCK), .o_ADC_CNV_n(o_ADC_CNV_n), .o_data(o_data),
        .o_rdy(o_rdy), .o_finished(o_finished), .o_busy(o_busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp_v, $time);
        end
    endtask

    // ADC sample table: lanes[conversion % 8][lane]
    logic [15:0] lanes [8][8];

    // Model state
    bit           m_active = 0;
    bit           m_pending = 0;
    longint       m_k = 0;
    logic [31:0]  m_n = 0;
    logic [31:0]  pend_n = 0;
    logic [127:0] e_data = '0;
    logic         prev_sck = 1'b0;
    longint       rise_in_run = 0;

    // Observed-event tallies and captured DUT values
    int           ev_rdy = 0, ev_fin = 0, ev_rise = 0, ev_cnvlow = 0, ev_busy = 0;
    longint       cyc = 0, last_rdy_cyc = 0, rdy_gap = 0;
    logic [127:0] cap_data = '0;

    always @(negedge clk) begin
        logic [3:0] e_cnv;
        logic       e_sck, e_rdy, e_fin, e_busy;
        longint     endk, p, s, j, r;
        cyc++;
        e_cnv = 4'hF; e_sck = 1'b0; e_rdy = 1'b0; e_fin = 1'b0; e_busy = 1'b0;
        if (rst) begin
            m_active = 0; m_pending = 0; e_data = '0; prev_sck = 1'b0;
        end else begin
            if (m_pending) begin
                m_active = 1; m_k = 1; m_n = pend_n; m_pending = 0; rise_in_run = 0;
            end else if (m_active) begin
                m_k++;
                if (m_k > PER * longint'(m_n) + 1) m_active = 0;
            end
            if (m_active) begin
                endk   = PER * longint'(m_n);
                e_busy = 1'b1;
                e_fin  = (m_k == endk + 1);
                if (m_k <= endk) begin
                    p     = (m_k - 1) % PER;
                    s     = p - SHIFT0;
                    e_cnv = (p < CNV_LOW) ? 4'h0 : 4'hF;
                    e_sck = (s >= 0) && (s < 2 * CLK_DIV * NB) && ((s % (2 * CLK_DIV)) >= CLK_DIV);
                    e_rdy = (p == PER - 1);
                    if (e_rdy) begin
                        j = (m_k - 1) / PER;
                        for (int l = 0; l < 8; l++)
                            e_data[16*l +: 16] = i_debug_en ? {j[12:0], l[2:0]} : lanes[j % 8][l];
                    end
                end
            end
        end
        chk("cnv_n", 128'(o_ADC_CNV_n), 128'(e_cnv));
        chk("sck", 128'(o_ADC_SCK), 128'({4{e_sck}}));
        chk("rdy", 128'(o_rdy), 128'(e_rdy));
        chk("finished", 128'(o_finished), 128'(e_fin));
        chk("busy", 128'(o_busy), 128'(e_busy));
        chk("data", o_data, e_data);

        if (!rst) begin
            if (o_rdy) begin
                ev_rdy++; cap_data = o_data; rdy_gap = cyc - last_rdy_cyc; last_rdy_cyc = cyc;
            end
            if (o_finished) ev_fin++;
            if (o_busy) ev_busy++;
            if (o_ADC_CNV_n != 4'hF) ev_cnvlow++;
            // ADC model: each SCK rise presents the next bit, MSB first
            if (o_ADC_SCK[0] && !prev_sck) begin
                ev_rise++;
                rise_in_run++;
                r = rise_in_run - 1;
                j = r / NB;
                for (int l = 0; l < 8; l++)
                    i_ADC_SDO[l] = lanes[j % 8][l][NB - 1 - (r % NB)];
            end
            prev_sck = o_ADC_SCK[0];
            if (!m_active && i_start && i_calib_done) begin
                m_pending = 1; pend_n = i_samples_count;
            end
        end
    end

    task automatic start_run(input logic [31:0] cnt);
        @(posedge clk); #1;
        i_start = 1'b1; i_samples_count = cnt;
        @(posedge clk); #1;
        i_start = 1'b0;
    endtask

    task automatic wait_idle(input string nm, input int budget);
        int n;
        for (n = 0; n < budget && (m_active || m_pending); n++) begin
            @(negedge clk); #1;
        end
        checks++;
        if (m_active || m_pending) begin
            errors++;
            $display("FAIL %s: run still active after %0d cycles, expected idle", nm, budget);
        end
    endtask

    task automatic fill_random();
        for (int c = 0; c < 8; c++)
            for (int l = 0; l < 8; l++) lanes[c][l] = 16'($urandom);
    endtask

    int b_rdy, b_fin, b_rise, b_cnv, b_busy;
    task automatic snap();
        b_rdy = ev_rdy; b_fin = ev_fin; b_rise = ev_rise; b_cnv = ev_cnvlow; b_busy = ev_busy;
    endtask

    initial begin
        rst = 1'b1; i_start = 1'b0; i_calib_done = 1'b1; i_samples_count = '0;
        i_debug_en = 1'b0; i_ADC_SDO = '0;
        fill_random();
        repeat (3) @(posedge clk);
        #1;
        chk("reset_cnv_n", 128'(o_ADC_CNV_n), 128'h0F);
        chk("reset_data", o_data, 128'd0);
        rst = 1'b0;

        // Fixed lane pattern, 3 conversions
        for (int c = 0; c < 8; c++)
            for (int l = 0; l < 8; l++) lanes[c][l] = 16'h0ABC + 16'(l) * 16'h1000;
        snap();
        start_run(32'd3);
        wait_idle("pattern_run", 400);
        chk("pattern_rdy_count", 128'(ev_rdy - b_rdy), 128'd3);
        chk("pattern_fin_count", 128'(ev_fin - b_fin), 128'd1);
        chk("pattern_sck_rises", 128'(ev_rise - b_rise), 128'd48);
        chk("pattern_rdy_gap", 128'(rdy_gap), 128'd87);
        chk("pattern_word", cap_data, 128'h7ABC_6ABC_5ABC_4ABC_3ABC_2ABC_1ABC_0ABC);

        // Zero-length run
        snap();
        start_run(32'd0);
        wait_idle("zero_run", 20);
        chk("zero_rdy_count", 128'(ev_rdy - b_rdy), 128'd0);
        chk("zero_fin_count", 128'(ev_fin - b_fin), 128'd1);
        chk("zero_cnv_low", 128'(ev_cnvlow - b_cnv), 128'd0);
        chk("zero_sck_rises", 128'(ev_rise - b_rise), 128'd0);

        // Start ignored without calibration
        i_calib_done = 1'b0;
        snap();
        start_run(32'd5);
        repeat (20) @(posedge clk);
        #1;
        chk("nocal_busy_cycles", 128'(ev_busy - b_busy), 128'd0);
        chk("nocal_fin_count", 128'(ev_fin - b_fin), 128'd0);
        i_calib_done = 1'b1;

        // Debug counter pattern
        i_debug_en = 1'b1;
        snap();
        start_run(32'd2);
        wait_idle("debug_run", 300);
        chk("debug_rdy_count", 128'(ev_rdy - b_rdy), 128'd2);
        chk("debug_word1_lane7", 128'(cap_data[127:112]), 128'h000F);
        chk("debug_word1_lane0", 128'(cap_data[15:0]), 128'h0008);
        i_debug_en = 1'b0;

        // Start pulse during a run is ignored
        fill_random();
        snap();
        start_run(32'd2);
        repeat (50) @(posedge clk);
        start_run(32'd5);
        wait_idle("restart_run", 400);
        chk("restart_rdy_count", 128'(ev_rdy - b_rdy), 128'd2);
        chk("restart_fin_count", 128'(ev_fin - b_fin), 128'd1);

        // Random runs, calibration dropping mid-run
        for (int t = 0; t < 5; t++) begin
            fill_random();
            start_run(32'($urandom_range(1, 4)));
            repeat ($urandom_range(5, 60)) @(posedge clk);
            #1;
            i_calib_done = 1'($urandom_range(0, 1));
            repeat ($urandom_range(5, 60)) @(posedge clk);
            #1;
            i_calib_done = 1'b1;
            wait_idle("random_run", 500);
        end

        // Full-range count, reset mid-SHIFT of the second conversion
        fill_random();
        snap();
        start_run(32'hFFFF_FFFF);
        for (int n = 0; n < 400 && !(m_active && m_k >= PER + 40); n++) begin
            @(negedge clk); #1;
        end
        chk("big_reached_shift", 128'(m_active && m_k >= PER + 40), 128'd1);
        chk("big_rdy_count", 128'(ev_rdy - b_rdy), 128'd1);
        chk("big_no_finish", 128'(ev_fin - b_fin), 128'd0);
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        chk("arst_cnv_n", 128'(o_ADC_CNV_n), 128'h0F);
        chk("arst_sck", 128'(o_ADC_SCK), 128'h0);
        chk("arst_rdy", 128'(o_rdy), 128'h0);
        chk("arst_busy", 128'(o_busy), 128'h0);
        chk("arst_finished", 128'(o_finished), 128'h0);
        @(posedge clk); #1;
        rst = 1'b0;

        fill_random();
        snap();
        start_run(32'd1);
        wait_idle("post_reset_run", 200);
        chk("post_reset_rdy", 128'(ev_rdy - b_rdy), 128'd1);
        chk("post_reset_fin", 128'(ev_fin - b_fin), 128'd1);
        chk("post_reset_rises", 128'(ev_rise - b_rise), 128'd16);
        repeat (3) @(posedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
